// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, FSM state encoding and response-class bit
//               positions for the ALU command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_SUB     = 4'b0001;
    localparam logic [3:0] OP_MUL     = 4'b0010;
    localparam logic [3:0] OP_DIV     = 4'b0011;
    localparam logic [3:0] OP_AND     = 4'b0100;
    localparam logic [3:0] OP_OR      = 4'b0101;
    localparam logic [3:0] OP_NAND    = 4'b0110;
    localparam logic [3:0] OP_NOR     = 4'b0111;
    localparam logic [3:0] OP_XOR     = 4'b1000;
    localparam logic [3:0] OP_XNOR    = 4'b1001;
    localparam logic [3:0] OP_CMP_EQ  = 4'b1010;
    localparam logic [3:0] OP_CMP_GT  = 4'b1011;
    localparam logic [3:0] OP_CMP_LT  = 4'b1100;
    localparam logic [3:0] OP_SHR     = 4'b1101;
    localparam logic [3:0] OP_SHL     = 4'b1110;
    localparam logic [3:0] OP_ILLEGAL = 4'b1111;

    // Bit positions inside the 4-bit response class {arith,logic,cmp,shift}
    localparam int CLS_ARITH = 3;
    localparam int CLS_LOGIC = 2;
    localparam int CLS_CMP   = 1;
    localparam int CLS_SHIFT = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } alu_state_e;

    function automatic logic [3:0] class_of(input logic [3:0] fun);
        logic [3:0] cls;
        cls = 4'b0000;
        case (fun)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV:                      cls[CLS_ARITH] = 1'b1;
            OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR:     cls[CLS_LOGIC] = 1'b1;
            OP_CMP_EQ, OP_CMP_GT, OP_CMP_LT:                     cls[CLS_CMP]   = 1'b1;
            OP_SHR, OP_SHL:                                      cls[CLS_SHIFT] = 1'b1;
            default:                                             cls = 4'b0000;
        endcase
        return cls;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer_if
// Description : Command, ALU-side and response signals of the sequencer.
//               master = sequencer view, slave = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_sequencer_if #(
    parameter int DATA_W = 16
);
    // Command channel; operands keep bit 0 as the MSB
    logic                cmd_valid;
    logic                cmd_ready;
    logic [3:0]          cmd_fun;
    logic [0:DATA_W-1]   cmd_a;
    logic [0:DATA_W-1]   cmd_b;

    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [3:0]          alu_fun;
    logic [DATA_W-1:0]   alu_out;
    logic                alu_arith_flag;
    logic                alu_logic_flag;
    logic                alu_cmp_flag;
    logic                alu_shift_flag;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_data;
    logic [3:0]          rsp_class;
    logic                rsp_err;
    logic [15:0]         op_count;

    modport master (
        input  cmd_valid, cmd_fun, cmd_a, cmd_b,
        input  alu_out, alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_fun,
        output rsp_valid, rsp_data, rsp_class, rsp_err, op_count
    );

    modport slave (
        output cmd_valid, cmd_fun, cmd_a, cmd_b,
        output alu_out, alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_fun,
        input  rsp_valid, rsp_data, rsp_class, rsp_err, op_count
    );

endinterface
`default_nettype wire

// File: rtl/alu_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_decode
// Description : Combinational classification of an offered command:
//               divide-by-zero, illegal opcode and expected result class.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_decode
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        cmd_fun_i,
    input  logic [0:DATA_W-1] cmd_b_i,
    output logic              div_zero_o,
    output logic              illegal_o,
    output logic [3:0]        exp_class_o
);

    assign div_zero_o  = (cmd_fun_i == OP_DIV) && (cmd_b_i == '0);
    assign illegal_o   = (cmd_fun_i == OP_ILLEGAL);
    assign exp_class_o = class_of(cmd_fun_i);

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Issues one command at a time to an external registered ALU,
//               captures flags and result, and holds a response until taken.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_cmd_sequencer_if.master   cmd_if
);

    alu_state_e          state_q, state_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [3:0]          alu_fun_q, alu_fun_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [3:0]          rsp_class_q, rsp_class_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [15:0]         op_count_q, op_count_d;

    logic                w_div_zero;
    logic                w_illegal;
    logic [3:0]          w_exp_class;
    logic [3:0]          w_alu_flags;

    alu_cmd_decode #(
        .DATA_W      (DATA_W)
    ) u_decode (
        .cmd_fun_i   (cmd_if.cmd_fun),
        .cmd_b_i     (cmd_if.cmd_b),
        .div_zero_o  (w_div_zero),
        .illegal_o   (w_illegal),
        .exp_class_o (w_exp_class)
    );

    assign w_alu_flags = {cmd_if.alu_arith_flag, cmd_if.alu_logic_flag,
                          cmd_if.alu_cmp_flag,   cmd_if.alu_shift_flag};

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        rsp_data_d  = rsp_data_q;
        rsp_class_d = rsp_class_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    // Error commands never reach the ALU, so its inputs keep
                    // the last legal command.
                    if (w_illegal) begin
                        rsp_data_d  = '0;
                        rsp_class_d = 4'b0000;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else if (w_div_zero) begin
                        rsp_data_d  = '0;
                        rsp_class_d = w_exp_class;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        alu_a_d   = cmd_if.cmd_a;
                        alu_b_d   = cmd_if.cmd_b;
                        alu_fun_d = cmd_if.cmd_fun;
                        state_d   = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                rsp_class_d = w_alu_flags;
                state_d     = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                rsp_data_d  = cmd_if.alu_out;
                rsp_err_d   = !is_onehot4(rsp_class_q);
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end

            ST_RESP: begin
                if (cmd_if.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= 4'b0000;
            rsp_data_q  <= '0;
            rsp_class_q <= 4'b0000;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            rsp_data_q  <= rsp_data_d;
            rsp_class_q <= rsp_class_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign cmd_if.cmd_ready = (state_q == ST_IDLE);
    assign cmd_if.alu_a     = alu_a_q;
    assign cmd_if.alu_b     = alu_b_q;
    assign cmd_if.alu_fun   = alu_fun_q;
    assign cmd_if.rsp_valid = rsp_valid_q;
    assign cmd_if.rsp_data  = rsp_data_q;
    assign cmd_if.rsp_class = rsp_class_q;
    assign cmd_if.rsp_err   = rsp_err_q;
    assign cmd_if.op_count  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Directed bench with a registered 16-bit ALU model on ALU_*.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_vec = 0;
    int         n_err = 0;
    int         lat;
    logic       flag_force_en = 1'b0;
    logic [3:0] flag_force    = 4'b0000;
    logic [3:0] model_cls;

    alu_cmd_sequencer_if #(.DATA_W(16)) bus ();

    alu_cmd_sequencer #(.DATA_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd_if (bus)
    );

    always #5 clk = ~clk;

    // Compare ops return a relation code: 1 = equal, 2 = greater, 4 = less
    function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] fun);
        logic [15:0] rel;
        rel = (a == b) ? 16'h0001 : ((a > b) ? 16'h0002 : 16'h0004);
        case (fun)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_MUL:    return a * b;
            OP_DIV:    return (b == 16'h0) ? 16'h0 : a / b;
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_NAND:   return ~(a & b);
            OP_NOR:    return ~(a | b);
            OP_XOR:    return a ^ b;
            OP_XNOR:   return ~(a ^ b);
            OP_CMP_EQ, OP_CMP_GT, OP_CMP_LT: return rel;
            OP_SHR:    return a >> b[3:0];
            OP_SHL:    return a << b[3:0];
            default:   return 16'h0;
        endcase
    endfunction

    always @(posedge clk) bus.alu_out <= alu_model(bus.alu_a, bus.alu_b, bus.alu_fun);

    always_comb begin
        model_cls          = flag_force_en ? flag_force : class_of(bus.alu_fun);
        bus.alu_arith_flag = model_cls[3];
        bus.alu_logic_flag = model_cls[2];
        bus.alu_cmp_flag   = model_cls[1];
        bus.alu_shift_flag = model_cls[0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b,
                        output int latency);
        int w;
        w = 0;
        while (!bus.cmd_ready && w < 20) begin
            tick();
            w++;
        end
        chk("accept_wait", {31'b0, bus.cmd_ready}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_fun   = fun;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_fun   = OP_SUB;
        bus.cmd_a     = 16'hDEAD;
        bus.cmd_b     = 16'h0000;
        latency = 1;
        while (!bus.rsp_valid && latency < 10) begin
            tick();
            latency++;
        end
    endtask

    task automatic check_rsp(input string tag, input int latency, input int exp_lat,
                             input logic [15:0] d, input logic [3:0] c, input logic e);
        chk({tag, "_lat"},   latency, exp_lat);
        chk({tag, "_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
        chk({tag, "_data"},  {16'b0, bus.rsp_data}, {16'b0, d});
        chk({tag, "_class"}, {28'b0, bus.rsp_class}, {28'b0, c});
        chk({tag, "_err"},   {31'b0, bus.rsp_err}, {31'b0, e});
    endtask

    task automatic handshake(input logic [15:0] exp_cnt);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("hs_valid_drop", {31'b0, bus.rsp_valid}, 32'd0);
        chk("hs_op_count",   {16'b0, bus.op_count}, {16'b0, exp_cnt});
        chk("hs_cmd_ready",  {31'b0, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_fun   = 4'b0000;
        bus.cmd_a     = 16'h0000;
        bus.cmd_b     = 16'h0000;
        bus.rsp_ready = 1'b0;

        // Reset values
        tick(); tick(); tick();
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data",  {16'b0, bus.rsp_data}, 32'd0);
        chk("rst_rsp_class", {28'b0, bus.rsp_class}, 32'd0);
        chk("rst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
        chk("rst_alu_a",     {16'b0, bus.alu_a}, 32'd0);
        chk("rst_alu_b",     {16'b0, bus.alu_b}, 32'd0);
        chk("rst_alu_fun",   {28'b0, bus.alu_fun}, 32'd0);
        chk("rst_op_count",  {16'b0, bus.op_count}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);

        // ADD 3 + 4
        send(OP_ADD, 16'h0003, 16'h0004, lat);
        check_rsp("add", lat, 3, 16'h0007, 4'b1000, 1'b0);
        chk("add_cnt_pre", {16'b0, bus.op_count}, 32'd0);
        handshake(16'd1);

        // Compare and shift
        send(OP_CMP_GT, 16'h0009, 16'h0002, lat);
        check_rsp("cmpgt", lat, 3, 16'h0002, 4'b0010, 1'b0);
        handshake(16'd2);
        send(OP_SHL, 16'h8001, 16'h0001, lat);
        check_rsp("shl", lat, 3, 16'h0002, 4'b0001, 1'b0);
        handshake(16'd3);

        // Divide by zero shortcut leaves ALU inputs at the SHL command
        send(OP_DIV, 16'h0010, 16'h0000, lat);
        check_rsp("div0", lat, 1, 16'h0000, 4'b1000, 1'b1);
        chk("div0_alu_fun", {28'b0, bus.alu_fun}, {28'b0, OP_SHL});
        chk("div0_alu_a",   {16'b0, bus.alu_a}, 32'h8001);
        handshake(16'd4);

        // Illegal opcode shortcut
        send(OP_ILLEGAL, 16'h1234, 16'h5678, lat);
        check_rsp("ill", lat, 1, 16'h0000, 4'b0000, 1'b1);
        chk("ill_alu_fun", {28'b0, bus.alu_fun}, {28'b0, OP_SHL});
        handshake(16'd5);

        // XOR with a stalled consumer and a competing command offered
        send(OP_XOR, 16'hFF00, 16'h0FF0, lat);
        check_rsp("xor", lat, 3, 16'hF0F0, 4'b0100, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_fun   = OP_ADD;
        bus.cmd_a     = 16'h0001;
        bus.cmd_b     = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_data",      {16'b0, bus.rsp_data}, 32'h0000F0F0);
            chk("stall_valid",     {31'b0, bus.rsp_valid}, 32'd1);
            chk("stall_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
            chk("stall_op_count",  {16'b0, bus.op_count}, 32'd5);
        end
        chk("stall_alu_a", {16'b0, bus.alu_a}, 32'h0000FF00);
        handshake(16'd6);
        chk("no_overlap_alu_a", {16'b0, bus.alu_a}, 32'h0000FF00);
        bus.cmd_valid = 1'b0;

        // ALU reporting a non-one-hot class
        flag_force_en = 1'b1;
        flag_force    = 4'b1010;
        send(OP_ADD, 16'h0001, 16'h0001, lat);
        check_rsp("badcls", lat, 3, 16'h0002, 4'b1010, 1'b1);
        flag_force_en = 1'b0;
        handshake(16'd7);

        // Reset while in CAPTURE
        bus.cmd_valid = 1'b1;
        bus.cmd_fun   = OP_SUB;
        bus.cmd_a     = 16'h0005;
        bus.cmd_b     = 16'h0003;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("capr_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("capr_rsp_data",  {16'b0, bus.rsp_data}, 32'd0);
        chk("capr_rsp_class", {28'b0, bus.rsp_class}, 32'd0);
        chk("capr_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
        chk("capr_alu_a",     {16'b0, bus.alu_a}, 32'd0);
        chk("capr_alu_fun",   {28'b0, bus.alu_fun}, 32'd0);
        chk("capr_op_count",  {16'b0, bus.op_count}, 32'd0);
        chk("capr_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        send(OP_SUB, 16'h0005, 16'h0003, lat);
        check_rsp("sub", lat, 3, 16'h0002, 4'b1000, 1'b0);
        handshake(16'd1);

        // Reset wins over a coinciding response handshake
        send(OP_AND, 16'h00FF, 16'h0F0F, lat);
        check_rsp("and", lat, 3, 16'h000F, 4'b0100, 1'b0);
        bus.rsp_ready = 1'b1;
        rst           = 1'b1;
        tick();
        rst           = 1'b0;
        bus.rsp_ready = 1'b0;
        chk("rsths_op_count", {16'b0, bus.op_count}, 32'd0);
        chk("rsths_valid",    {31'b0, bus.rsp_valid}, 32'd0);

        // Counter wrap: preload near the top, then cross with real handshakes
        force dut.op_count_q = 16'hFFFD;
        tick();
        release dut.op_count_q;
        tick();
        chk("wrap_preload", {16'b0, bus.op_count}, 32'h0000FFFD);
        send(OP_ILLEGAL, 16'h0000, 16'h0000, lat);
        handshake(16'hFFFE);
        send(OP_DIV, 16'h0001, 16'h0000, lat);
        handshake(16'hFFFF);
        send(OP_ILLEGAL, 16'h0000, 16'h0000, lat);
        handshake(16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
